multiplier_8bit: RTL and testbench



---
 rtl/multiplier_8bit_pkg.sv | 13 +
 rtl/multiplier_8bit_full_adder.sv | 22 ++
 rtl/multiplier_8bit.sv | 75 +++++++
 tb/tb_multiplier_8bit.sv | 119 +++++++++++
 4 files changed

// File: rtl/multiplier_8bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_8bit_pkg
// Description : Width and reset constants shared by the 8x8 array multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package multiplier_8bit_pkg;

  localparam int unsigned WIDTH = 8;
  localparam logic [WIDTH-1:0] RESET_VALUE = '0;

endpackage : multiplier_8bit_pkg
`default_nettype wire

// File: rtl/multiplier_8bit_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_8bit_full_adder
// Description : Single-bit full adder cell used in the multiplier adder array.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_8bit_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_half;

  assign w_half = i_a ^ i_b;
  assign o_sum  = w_half ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & w_half);

endmodule : multiplier_8bit_full_adder
`default_nettype wire

// File: rtl/multiplier_8bit.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_8bit
// Description : 8x8 shift-and-add array multiplier, low byte registered.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_8bit
  import multiplier_8bit_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] Product
);

  logic [WIDTH-1:0] product_d;
  logic [WIDTH-1:0] product_q;

  // Row i holds the running sum after adding partial-product row i << i.
  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    logic [WIDTH-1:0] w_sum;

    if (i == 0) begin : g_first
      assign w_sum = DATA1 & {WIDTH{DATA2[0]}};
    end else begin : g_add
      // Bits below the row shift are untouched by this row.
      assign w_sum[i-1:0] = g_row[i-1].w_sum[i-1:0];

      for (genvar k = 0; k < WIDTH - i; k++) begin : g_col
        logic w_pp;
        logic w_cin;
        logic w_cout;

        assign w_pp = DATA1[k] & DATA2[i];

        if (k == 0) begin : g_lsb
          assign w_cin = 1'b0;
        end else begin : g_chain
          assign w_cin = g_col[k-1].w_cout;
        end

        multiplier_8bit_full_adder u_fa (
          .i_a    (g_row[i-1].w_sum[i+k]),
          .i_b    (w_pp),
          .i_cin  (w_cin),
          .o_sum  (w_sum[i+k]),
          .o_cout (w_cout)
        );

        // Carry out of bit 7 is part of the discarded high byte.
        if (k == WIDTH - 1 - i) begin : g_drop
          logic w_unused_cout;
          assign w_unused_cout = w_cout;
        end
      end
    end
  end

  always_comb begin
    product_d = g_row[WIDTH-1].w_sum;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      product_q <= RESET_VALUE;
    end else begin
      product_q <= product_d;
    end
  end

  assign Product = product_q;

endmodule : multiplier_8bit
`default_nettype wire

// File: tb/tb_multiplier_8bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier_8bit
// Description : Directed and exhaustive self-checking bench for multiplier_8bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [7:0] product;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [6];

  multiplier_8bit dut (
    .CLK     (clk),
    .RESET   (rst),
    .DATA1   (data1),
    .DATA2   (data2),
    .Product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vecs[0] = '{"trunc_10x10", 8'h10, 8'h10, 8'h00};
    vecs[1] = '{"trunc_14x0d", 8'h14, 8'h0D, 8'h04};
    vecs[2] = '{"signed_fex03", 8'hFE, 8'h03, 8'hFA};
    vecs[3] = '{"signed_ffxff", 8'hFF, 8'hFF, 8'h01};
    vecs[4] = '{"zero_00xa7", 8'h00, 8'hA7, 8'h00};
    vecs[5] = '{"ident_01xa7", 8'h01, 8'hA7, 8'hA7};

    rst   = 1'b1;
    data1 = 8'd3;
    data2 = 8'd5;
    #1 check("reset_initial", product, 8'h00);

    // Edges while reset is held must not load.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", product, 8'h00);

    rst = 1'b0;
    @(negedge clk);
    check("reset_release", product, 8'h0F);

    data1 = 8'd7;
    data2 = 8'd9;
    @(negedge clk);
    check("load_7x9", product, 8'h3F);

    // Asynchronous clear between edges with nonzero operands.
    #2 rst = 1'b1;
    #1 check("reset_async", product, 8'h00);
    @(negedge clk);
    check("reset_async_edge", product, 8'h00);
    data1 = 8'd3;
    data2 = 8'd5;
    rst   = 1'b0;
    @(negedge clk);
    check("reset_async_release", product, 8'h0F);

    foreach (vecs[n]) begin
      data1 = vecs[n].a;
      data2 = vecs[n].b;
      @(negedge clk);
      check(vecs[n].tag, product, vecs[n].exp);
    end

    // Operand change mid-cycle is invisible until the next edge.
    data1 = 8'd2;
    data2 = 8'd7;
    @(negedge clk);
    check("latency_first", product, 8'h0E);
    data1 = 8'd4;
    data2 = 8'd4;
    #2 check("latency_hold", product, 8'h0E);
    @(posedge clk);
    #1 check("latency_next", product, 8'h10);

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        logic [15:0] full;
        data1 = a[7:0];
        data2 = b[7:0];
        full  = a[7:0] * b[7:0];
        @(posedge clk);
        #1 check("sweep", product, full[7:0]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_multiplier_8bit
`default_nettype wire
